// File: rtl/imem_loader.sv
// Byte-stream loader for the 1024x32 instruction RAM: length header, LE word assembly, sequential writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd5
  } state_t;
`endif

  state_t       state_q, state_d;
  logic [7:0]   len_lo_q, len_lo_d;
  logic [10:0]  len_q, len_d;
  logic [1:0]   byte_cnt_q, byte_cnt_d;
  logic [10:0]  word_cnt_q, word_cnt_d;
  logic [23:0]  buf_q, buf_d;
  logic         wr_en_q, wr_en_d;
  logic [9:0]   wr_addr_q, wr_addr_d;
  logic [31:0]  wr_data_q, wr_data_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         active_q, active_d;
  logic         accept_s;
  logic [15:0]  len_field_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]   csum_q, csum_d;
`endif

  assign accept_s    = in_valid && active_q;
  assign len_field_s = {in_data, len_lo_q};

  // Next-state and datapath for the load sequence.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    buf_d      = buf_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          wr_addr_d  = 10'd0;
          word_cnt_d = 11'd0;
          byte_cnt_d = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = 8'd0;
`endif
          state_d    = S_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_LO: begin
        if (accept_s) begin
          len_lo_d = in_data;
          state_d  = S_LEN_HI;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN_HI: begin
        if (accept_s) begin
          // Reserved high bits, zero and oversize lengths all abort before any write.
          if ((len_field_s[15:11] != 5'd0) || (len_field_s == 16'd0) || (len_field_s > MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            len_d   = len_field_s[10:0];
            state_d = S_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DATA: begin
        if (accept_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_next(csum_q, in_data);
`endif
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_data_d  = {in_data, buf_q};
            wr_addr_d  = word_cnt_q[9:0];
            word_cnt_d = word_cnt_q + 11'd1;
            byte_cnt_d = 2'd0;
            if (word_cnt_q == (len_q - 11'd1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              done_d  = 1'b1;
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_DATA;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
              2'd0:    buf_d[7:0]   = in_data;
              2'd1:    buf_d[15:8]  = in_data;
              2'd2:    buf_d[23:16] = in_data;
              default: buf_d        = buf_q;
            endcase
          end
        end else begin
          state_d = state_q;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept_s) begin
          done_d  = 1'b1;
          err_d   = (in_data != csum_q);
          state_d = S_DONE;
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // in_ready and busy share one decode: both high only inside a load.
    if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
      active_d = 1'b0;
    end else begin
      active_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_lo_q   <= 8'd0;
      len_q      <= 11'd0;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 11'd0;
      buf_q      <= 24'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 10'd0;
      wr_data_q  <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      buf_q      <= buf_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      active_q   <= active_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign in_ready = active_q;
  assign busy     = active_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; inputs change and outputs are sampled on the falling edge.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  // Write monitor: logs every sampled write and counts back-to-back high samples.
  int          wr_cnt = 0;
  int          wide_cnt = 0;
  logic        prev_wr = 1'b0;
  logic [9:0]  log_addr [0:2047];
  logic [31:0] log_data [0:2047];

  imem_loader #(.MAX_WORDS(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (wr_cnt < 2048) begin
        log_addr[wr_cnt] = wr_addr;
        log_data[wr_cnt] = wr_data;
      end
      wr_cnt = wr_cnt + 1;
      if (prev_wr === 1'b1) wide_cnt = wide_cnt + 1;
    end
    prev_wr = wr_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Trailing checksum byte, only in the checksum build.
  task automatic finish_load(input logic [7:0] cs);
`ifdef IMEM_LOADER_CHECKSUM_EN
    put(cs);
`else
    if (cs == 8'hFF) @(negedge clk);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".outs"}, {in_ready, wr_en, busy, done, err}, 32'd0);
    chk({tag, ".addr"}, {22'd0, wr_addr}, 32'd0);
    chk({tag, ".data"}, wr_data, 32'd0);
  endtask

  int base;

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single word load
    base = wr_cnt;
    pulse_start();
    chk("t1.ready", {31'd0, in_ready}, 32'd1);
    put(8'h01); put(8'h00);
    put(8'h78); put(8'h56); put(8'h34); put(8'h12);
    chk("t1.wr_en", {31'd0, wr_en}, 32'd1);
    chk("t1.addr", {22'd0, wr_addr}, 32'd0);
    chk("t1.data", wr_data, 32'h12345678);
    finish_load(8'h08);
    chk("t1.done", {31'd0, done}, 32'd1);
    chk("t1.busy", {31'd0, busy}, 32'd0);
    chk("t1.err", {31'd0, err}, 32'd0);
    idle();
    chk("t1.wr_drop", {31'd0, wr_en}, 32'd0);
    chk("t1.count", 32'(wr_cnt - base), 32'd1);

    // Three words with in_valid toggled every other cycle
    base = wr_cnt;
    pulse_start();
    chk("t2.done_clr", {31'd0, done}, 32'd0);
    put(8'h03); idle(); put(8'h00); idle();
    for (int i = 0; i < 12; i++) begin
      put(8'(8'h10 + i));
      idle();
    end
    finish_load(8'h00);
    idle();
    chk("t2.count", 32'(wr_cnt - base), 32'd3);
    chk("t2.wide", 32'(wide_cnt), 32'd0);
    chk("t2.a0", {22'd0, log_addr[base]}, 32'd0);
    chk("t2.d0", log_data[base], 32'h13121110);
    chk("t2.a1", {22'd0, log_addr[base+1]}, 32'd1);
    chk("t2.d1", log_data[base+1], 32'h17161514);
    chk("t2.a2", {22'd0, log_addr[base+2]}, 32'd2);
    chk("t2.d2", log_data[base+2], 32'h1B1A1918);
    chk("t2.done", {31'd0, done}, 32'd1);

    // Bad lengths: 0, 1025, reserved bit 11 set
    base = wr_cnt;
    pulse_start();
    put(8'h00); put(8'h00);
    chk("t3.err0", {31'd0, err}, 32'd1);
    chk("t3.busy0", {31'd0, busy}, 32'd0);
    chk("t3.ready0", {31'd0, in_ready}, 32'd0);
    chk("t3.done0", {31'd0, done}, 32'd0);
    pulse_start();
    chk("t3.err_clr", {31'd0, err}, 32'd0);
    put(8'h01); put(8'h04);
    chk("t3.err1025", {31'd0, err}, 32'd1);
    idle();
    chk("t3.ready1025", {31'd0, in_ready}, 32'd0);
    pulse_start();
    put(8'h00); put(8'h08);
    chk("t3.err_b11", {31'd0, err}, 32'd1);
    put(8'h55); put(8'h66);
    idle();
    chk("t3.idle_ready", {31'd0, in_ready}, 32'd0);
    chk("t3.count", 32'(wr_cnt - base), 32'd0);

    // Full 1024-word continuous stream
    base = wr_cnt;
    pulse_start();
    put(8'h00); put(8'h04);
    chk("t4.busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 1024; k++) begin
      put(8'(k)); put(8'(k >> 8)); put(8'h00); put(8'hA5);
    end
    chk("t4.last_addr", {22'd0, wr_addr}, 32'd1023);
    chk("t4.last_data", wr_data, 32'hA50003FF);
    finish_load(8'h00);
    chk("t4.done", {31'd0, done}, 32'd1);
    idle(); idle(); idle();
    chk("t4.count", 32'(wr_cnt - base), 32'd1024);
    chk("t4.first", {12'd0, log_addr[base], 10'd0}, {12'd0, 10'd0, 10'd0});
    chk("t4.mid", {22'd0, log_addr[base+512]}, 32'd512);
    chk("t4.mid_d", log_data[base+512], 32'hA5000200);
    chk("t4.wide", 32'(wide_cnt), 32'd0);
    chk("t4.addr_hold", {22'd0, wr_addr}, 32'd1023);

    // Reset mid-load after 2 of 3 words, then a fresh single-word load
    pulse_start();
    put(8'h03); put(8'h00);
    for (int i = 0; i < 8; i++) put(8'(8'h40 + i));
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("t5.rst_async");
    @(negedge clk);
    chk_all_zero("t5.rst_held");
    rst = 1'b0;
    @(negedge clk);
    base = wr_cnt;
    pulse_start();
    put(8'h01); put(8'h00);
    put(8'hEF); put(8'hBE); put(8'hAD); put(8'hDE);
    chk("t5.addr", {22'd0, wr_addr}, 32'd0);
    chk("t5.data", wr_data, 32'hDEADBEEF);
    finish_load(8'h22);
    idle();
    chk("t5.done", {31'd0, done}, 32'd1);
    chk("t5.count", 32'(wr_cnt - base), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good and bad
    pulse_start();
    put(8'h01); put(8'h00);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    chk("t6.busy_csum", {31'd0, busy}, 32'd1);
    chk("t6.done_early", {31'd0, done}, 32'd0);
    put(8'h44);
    chk("t6.good_done", {31'd0, done}, 32'd1);
    chk("t6.good_err", {31'd0, err}, 32'd0);
    pulse_start();
    put(8'h01); put(8'h00);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    put(8'h45);
    chk("t6.bad_done", {31'd0, done}, 32'd1);
    chk("t6.bad_err", {31'd0, err}, 32'd1);
`endif

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial instruction-memory loader: the write-side counterpart of the CPU's read-only 1024×32 instruction store. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and issues single-cycle writes at sequential 10-bit word addresses into the instruction RAM. It sits between a byte source (UART receiver or testbench host) and the instruction memory's write port, and holds the CPU in reset (`busy`) while a program image is being loaded.

## Interface
Parameters:
- `MAX_WORDS`, 1024, capacity in 32-bit words; the address width is fixed at 10 bits.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that arms a new load.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `wr_en` out 1: instruction-RAM write strobe, high for exactly one cycle per word.
- `wr_addr` out 10: word address of the write.
- `wr_data` out 32: word to write.
- `busy` out 1: load in progress; drives the CPU hold.
- `done` out 1: sticky, set when a load completes.
- `err` out 1: sticky, set on a bad length or bad checksum.

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM (present only with the macro), DONE.
- Reset: state IDLE. All outputs are 0: `in_ready`, `wr_en`, `wr_addr`, `wr_data`, `busy`, `done`, `err`. The internal byte counter, word counter, length register and checksum are cleared.
- IDLE or DONE + `start`: clear `done`, `err`, word address and checksum; go to LEN_LO. `start` in any other state is ignored.
- LEN_LO / LEN_HI: the first two accepted bytes form an 11-bit word count N, little-endian; bits [15:11] of the 16-bit field must be 0.
- Length check on the LEN_HI accept: if N==0 or N>MAX_WORDS, set `err`, go to IDLE, and perform no writes. Otherwise go to DATA.
- DATA: bytes are accepted in groups of 4. The first byte of a group maps to `wr_data[7:0]` and the fourth to `wr_data[31:24]`. The word address starts at 0 and increments after each write.
- After the 4th byte of word N−1: go to CSUM if the macro is defined, otherwise go to DONE with `done`=1.
- `in_ready`: 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 in IDLE and DONE. The memory write never stalls, so there is no backpressure inside a load.
- `busy`: 1 in every state except IDLE and DONE.
- Bytes arriving while `in_ready`=0 are not consumed.
- Address never wraps: the length check guarantees the last address is N−1 ≤ 1023.

## Timing
- A byte is consumed on the edge where `in_valid && in_ready`. Gaps (`in_valid`=0) are allowed anywhere, with no timeout.
- Write latency: `wr_en`, `wr_addr` and `wr_data` are registered on the edge that accepts the 4th byte of a word. They are valid for the following cycle only, and `wr_en` drops on the next edge. `wr_data`/`wr_addr` hold their last value.
- Maximum throughput is 1 byte per cycle, so a write occurs at most every 4 cycles.
- `done` (no-checksum build) rises on the same edge as the final `wr_en`.
- Length error: `err` rises on the LEN_HI accept edge, and `busy` falls on the same edge.
- `rst` mid-load aborts immediately. Partially written memory contents are not restored.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last data byte, the loader enters CSUM and accepts one byte.
  - If that byte equals the XOR of all 4N data bytes (length bytes excluded), `done`=1.
  - On mismatch, `done`=1 and `err`=1; words already written remain.
  - `done`/`err` rise on the CSUM accept edge.
- Undefined: there is no CSUM state and no checksum logic; `err` is only set by a length error.

## Test plan
- Reset, then check all outputs are 0. `start`, then send 01 00 78 56 34 12 (no-checksum build) → one `wr_en` pulse with `wr_addr`=0 and `wr_data`=0x12345678; `done`=1; `busy`=0.
- N=3 with `in_valid` toggled every other cycle → writes at addresses 0, 1, 2 with the correct words; exactly 3 `wr_en` pulses, each one cycle wide.
- Bad lengths: length bytes 00 00, and separately 01 04 (1025) → `err`=1, no `wr_en`, state IDLE, `in_ready`=0.
- N=1024 continuous stream → last write at `wr_addr`=1023, then `done`; no wrap to address 0.
- `rst` asserted after 2 of 3 words, then `start` with N=1 → outputs 0 during reset, and the new load writes at address 0.
- Checksum build: N=1, data 11 22 33 44 with checksum 0x44 → `done`=1, `err`=0. Checksum 0x45 → `done`=1, `err`=1.
